// File: rtl/fir_interp_dac.sv
// Polyphase FIR interpolator for the DAC output path: one input sample yields L filtered
// output samples, each produced by a single time-multiplexed MAC, then rounded and saturated.
//
// state | meaning
// IDLE  | waiting for an input sample (din_ready high)
// MAC   | accumulating the M taps of the current phase, one tap per cycle
// SAT   | rounding and saturating the accumulator into dout
// OUT   | presenting dout until the DAC consumer takes it
module fir_interp_dac #(
   parameter int L         = 4,
   parameter int TAPS      = 32,
   parameter int WIDTH     = 14,
   parameter int OUT_WIDTH = 14,
   parameter int SHIFT     = 13,
   // Packed with coefficient 0 in the least significant 16 bits.
   parameter logic [TAPS*16-1:0] COEFF_SET = {
      16'(-54),  16'(-64),  16'(-82),  16'(-97),  16'(-93),  16'(-47),  16'(66),   16'(266),
      16'(562),  16'(951),  16'(1412), 16'(1909), 16'(2396), 16'(2821), 16'(3136), 16'(3304),
      16'(3304), 16'(3136), 16'(2821), 16'(2396), 16'(1909), 16'(1412), 16'(951),  16'(562),
      16'(266),  16'(66),   16'(-47),  16'(-93),  16'(-97),  16'(-82),  16'(-64),  16'(-54)
   }
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic signed [WIDTH-1:0]     din,
   input  logic                        din_valid,
   output logic                        din_ready,
   output logic signed [OUT_WIDTH-1:0] dout,
   output logic                        dout_valid,
   input  logic                        dout_ready
);

   localparam int M      = TAPS / L;
   localparam int PW     = $clog2(L);
   localparam int KW     = (M > 1) ? $clog2(M) : 1;
   localparam int IW     = $clog2(TAPS);
   localparam int PROD_W = WIDTH + 16;
   localparam int ACC_W  = WIDTH + 16 + $clog2(M);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MAC  = 2'd1;
   localparam logic [1:0] SAT  = 2'd2;
   localparam logic [1:0] OUT  = 2'd3;

   localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(1) <<< (SHIFT - 1);
   localparam logic signed [ACC_W:0] SAT_MAX = ((ACC_W+1)'(1) <<< (OUT_WIDTH - 1)) - (ACC_W+1)'(1);
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

   logic [1:0]                  state;
   logic [PW-1:0]               phase;
   logic [KW-1:0]               k;
   logic signed [ACC_W-1:0]     acc;
   logic signed [WIDTH-1:0]     x [M];
   logic signed [15:0]          coeff [TAPS];

   logic                        in_xfer;
   logic [IW-1:0]               c_idx;
   logic signed [15:0]          coeff_cur;
   logic signed [WIDTH-1:0]     x_cur;
   logic signed [PROD_W-1:0]    prod;
   logic signed [ACC_W:0]       acc_rnd;
   logic signed [ACC_W:0]       acc_shf;
   logic signed [OUT_WIDTH-1:0] sat_val;

   for (genvar i = 0; i < TAPS; i++) begin : g_coeff
      assign coeff[i] = COEFF_SET[i*16 +: 16];
   end

   // Held low during reset so nothing is offered as accepted while n_rst is asserted.
   assign din_ready = n_rst & (state == IDLE);
   assign in_xfer   = din_valid & din_ready;

   // Branch p of the prototype uses taps p, p+L, p+2L, ...
   assign c_idx     = IW'(int'(phase) + L * int'(k));
   assign coeff_cur = coeff[c_idx];
   assign x_cur     = x[k];
   assign prod      = PROD_W'(coeff_cur) * PROD_W'(x_cur);

   assign acc_rnd   = (ACC_W+1)'(acc) + RND;
   assign acc_shf   = acc_rnd >>> SHIFT;

   always_comb begin
      sat_val = acc_shf[OUT_WIDTH-1:0];
      if (acc_shf > SAT_MAX) begin
         sat_val = SAT_MAX[OUT_WIDTH-1:0];
      end else if (acc_shf < SAT_MIN) begin
         sat_val = SAT_MIN[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < M; i++) begin
            x[i] <= '0;
         end
      end else if (in_xfer) begin
         x[0] <= din;
         for (int i = 1; i < M; i++) begin
            x[i] <= x[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         phase      <= '0;
         k          <= '0;
         acc        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_xfer) begin
                  phase <= '0;
                  k     <= '0;
                  acc   <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               acc <= acc + ACC_W'(prod);
               if (k == KW'(M - 1)) begin
                  state <= SAT;
               end else begin
                  k <= k + 1'b1;
               end
            end
            SAT: begin
               dout       <= sat_val;
               dout_valid <= 1'b1;
               state      <= OUT;
            end
            OUT: begin
               if (dout_ready) begin
                  dout_valid <= 1'b0;
                  if (phase == PW'(L - 1)) begin
                     state <= IDLE;
                  end else begin
                     phase <= phase + 1'b1;
                     k     <= '0;
                     acc   <= '0;
                     state <= MAC;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
